maxpool2x2: RTL and testbench

- 2×2, stride-2 max-pooling stage directly downstream of the CNN convolution engine.
- Consumes the raster-ordered stream of convolution results, i.e. one value per conv-engine oValid pulse, IW×IW values per frame.
- Emits one pooled maximum per non-overlapping 2×2 block, in raster order: (IW/2)×(IW/2) values per frame.
- Uses a half-width row buffer, so the input is never stalled.

---
 rtl/maxpool2x2.sv | 89 ++++++++
 tb/tb_maxpool2x2.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool2x2.sv
// 2x2 stride-2 max-pooling stage behind the conv engine.
// Raster input stream in, one signed maximum per 2x2 block out.
module maxpool2x2 #(
  parameter int IW = 28,
  parameter int DW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iValid,
  input  logic signed [DW-1:0] iData,
  output logic                 oValid,
  output logic signed [DW-1:0] oData,
  output logic                 oDone
);

  localparam int CW = (IW > 1) ? $clog2(IW) : 1;
  localparam int HW = IW / 2;
  localparam int KW = (HW > 1) ? $clog2(HW) : 1;

  logic [CW-1:0]        col;
  logic [CW-1:0]        row;
  logic signed [DW-1:0] hreg;
  logic signed [DW-1:0] rowBuf [HW];

  logic [KW-1:0]        k;
  logic signed [DW-1:0] h;
  logic signed [DW-1:0] v;
  logic                 lastCol;
  logic                 lastRow;

  assign lastCol = (col == CW'(IW - 1));
  assign lastRow = (row == CW'(IW - 1));

  // Horizontal pair max, then vertical max against the buffered upper row.
  always_comb begin
    k = KW'(col >> 1);
    h = (iData > hreg) ? iData : hreg;
    v = (rowBuf[k] > h) ? rowBuf[k] : h;
  end

  // Raster position counters, advanced on accepted samples only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (iValid) begin
      if (lastCol) begin
        col <= '0;
        row <= lastRow ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Left sample of each horizontal pair waits here for its partner.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hreg <= '0;
    end else if (iValid && !col[0]) begin
      hreg <= iData;
    end
  end

  // Even rows park their pair maxima; every entry is written before read.
  always_ff @(posedge clk) begin
    if (rst && iValid && col[0] && !row[0]) begin
      rowBuf[k] <= h;
    end
  end

  // Odd-row, odd-column samples close a block and emit its maximum.
  always_ff @(posedge clk) begin
    if (!rst) begin
      oValid <= 1'b0;
      oData  <= '0;
      oDone  <= 1'b0;
    end else begin
      oValid <= 1'b0;
      oDone  <= 1'b0;
      if (iValid && col[0] && row[0]) begin
        oValid <= 1'b1;
        oData  <= v;
        oDone  <= lastCol && lastRow;
      end
    end
  end

endmodule

// File: tb/tb_maxpool2x2.sv
// Scoreboard bench for maxpool2x2.
// Main instance IW=28/DW=16; small IW=2/DW=8 instance for signed cases.
module tb_maxpool2x2;

  localparam int IW = 28;
  localparam int DW = 16;
  localparam int NS = IW * IW;
  localparam int NO = (IW / 2) * (IW / 2);

  typedef struct {
    int d;
    bit done;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 iValid;
  logic signed [DW-1:0] iData;
  logic                 oValid;
  logic signed [DW-1:0] oData;
  logic                 oDone;

  logic                 bValid;
  logic signed [7:0]    bData;
  logic                 bOValid;
  logic signed [7:0]    bOData;
  logic                 bODone;

  int   nVec = 0;
  int   nBad = 0;
  exp_t sb[$];
  int   outLog[$];
  int   refLog[$];
  int   outCnt = 0;
  int   doneCnt = 0;
  int   pix [IW][IW];
  logic finFlag = 1'b0;
  logic finPrev = 1'b0;

  always #5 clk = ~clk;

  maxpool2x2 #(.IW(IW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .iValid(iValid), .iData(iData),
    .oValid(oValid), .oData(oData), .oDone(oDone)
  );

  maxpool2x2 #(.IW(2), .DW(8)) dutB (
    .clk(clk), .rst(rst),
    .iValid(bValid), .iData(bData),
    .oValid(bOValid), .oData(bOData), .oDone(bODone)
  );

  task automatic check(input string tag, input int got, input int exp);
    nVec++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  always @(posedge clk) finPrev <= rst && iValid && finFlag;

  // Monitor: latency, scoreboard pop, done alignment
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (oValid || finPrev) check("latency", int'(oValid), int'(finPrev));
      if (oDone && !oValid) check("doneAlone", 1, 0);
      if (oValid) begin
        if (sb.size() == 0) begin
          check("spurious", 1, 0);
        end else begin
          e = sb.pop_front();
          check("data", int'(oData), e.d);
          check("done", int'(oDone), int'(e.done));
        end
        outLog.push_back(int'(oData));
        outCnt++;
        if (oDone) doneCnt++;
      end
    end
  end

  task automatic idleCyc();
    @(posedge clk);
    #1;
    iValid  = 1'b0;
    finFlag = 1'b0;
  endtask

  task automatic sendFrame(input int mode, input int idle, input int nSamp);
    int r, c, v, m;
    exp_t e;
    for (int i = 0; i < nSamp; i++) begin
      r = i / IW;
      c = i % IW;
      while (idle > 0 && $urandom_range(99) < idle) idleCyc();
      v = (mode != 0) ? (NS - 1 - i) : i;
      pix[r][c] = v;
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        m = max2(max2(pix[r-1][c-1], pix[r-1][c]),
                 max2(pix[r][c-1], v));
        e.d = m;
        e.done = (r == IW - 1) && (c == IW - 1);
        sb.push_back(e);
      end
      @(posedge clk);
      #1;
      iValid  = 1'b1;
      iData   = DW'(v);
      finFlag = (r % 2 == 1) && (c % 2 == 1);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
    check("drain", sb.size(), 0);
    @(negedge clk);
  endtask

  task automatic clearLog();
    outLog.delete();
    outCnt = 0;
    doneCnt = 0;
  endtask

  task automatic cmpRef(input string tag);
    int diff = 0;
    if (outLog.size() != refLog.size()) diff++;
    else
      for (int i = 0; i < refLog.size(); i++)
        if (outLog[i] != refLog[i]) diff++;
    check(tag, diff, 0);
  endtask

  task automatic blockB(input int a, input int b, input int c,
                        input int d, input int exp, input string tag);
    int s [4];
    s[0] = a; s[1] = b; s[2] = c; s[3] = d;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      bValid = 1'b1;
      bData  = 8'(s[i]);
    end
    @(posedge clk);
    #1;
    bValid = 1'b0;
    @(negedge clk);
    check({tag, "_v"}, int'(bOValid), 1);
    check({tag, "_d"}, int'(bOData), exp);
    check({tag, "_done"}, int'(bODone), 1);
  endtask

  initial begin
    rst    = 1'b0;
    iValid = 1'b0;
    iData  = '0;
    bValid = 1'b0;
    bData  = '0;

    // Test 1: reset with toggling iValid
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      iValid = ~iValid;
      iData  = DW'($urandom_range(1000));
      @(negedge clk);
      check("rstValid", int'(oValid), 0);
      check("rstData", int'(oData), 0);
      check("rstDone", int'(oDone), 0);
    end
    @(posedge clk);
    #1;
    iValid = 1'b0;
    rst    = 1'b1;

    // Test 2: contiguous frame
    clearLog();
    sendFrame(0, 0, NS);
    idleCyc();
    drain();
    check("t2Outs", outCnt, NO);
    check("t2Dones", doneCnt, 1);
    check("t2First", (outLog.size() > 0) ? outLog[0] : -1, 29);
    check("t2Last", (outLog.size() == NO) ? outLog[NO-1] : -1, 783);
    refLog = outLog;

    // Test 4: random gaps
    clearLog();
    sendFrame(0, 40, NS);
    idleCyc();
    drain();
    check("t4Outs", outCnt, NO);
    check("t4Dones", doneCnt, 1);
    cmpRef("t4Seq");

    // Test 5: two back-to-back frames
    clearLog();
    sendFrame(0, 0, NS);
    sendFrame(1, 0, NS);
    idleCyc();
    drain();
    check("t5Outs", outCnt, 2 * NO);
    check("t5Dones", doneCnt, 2);
    check("t5F2First", (outLog.size() > NO) ? outLog[NO] : -1, 783);
    check("t5F2Last", (outLog.size() == 2 * NO) ? outLog[2*NO-1] : -1, 29);

    // Test 6: reset after sample (3,10)
    clearLog();
    sendFrame(0, 0, 3 * IW + 11);
    idleCyc();
    drain();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("t6RstValid", int'(oValid), 0);
    check("t6RstData", int'(oData), 0);
    sb.delete();
    clearLog();
    sendFrame(0, 0, NS);
    idleCyc();
    drain();
    check("t6Outs", outCnt, NO);
    check("t6Dones", doneCnt, 1);
    cmpRef("t6Seq");

    // Test 3: signed values, DW=8
    blockB(-5, -3, -128, -1, -1, "neg1");
    blockB(-128, -128, -128, -127, -127, "neg2");
    blockB(-128, -128, -128, -128, -128, "neg3");
    blockB(7, -2, 3, 6, 7, "mix");
    blockB(5, 5, 5, 5, 5, "tie");
    @(negedge clk);
    check("bIdle", int'(bOValid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

endmodule
